mdu_hilo: RTL

Multiply/divide front-end and HI/LO register file for the MIPS core. Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO issues from the decode/execute stage, drives operand magnitudes into the external 64-bit unsigned multiplier `MULT` and consumes its product. Applies sign correction, runs a 32-step restoring divider internally and holds HI/LO for MFHI/MFLO. Asserts `busy` so the core stalls MFHI/MFLO and further MDU issues until the result is committed.

---
 rtl/mdu_hilo.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/mdu_hilo.sv
// MIPS multiply/divide front-end with HI/LO: multiplies take MUL_LAT cycles via external MULT, divides 32, MT ops and divide-by-zero 0.
// No backpressure: busy is a stall request and issues arriving while busy are dropped.
module mdu_hilo #(
    parameter int MUL_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [63:0] mul_z,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int CW = (MUL_LAT > 32) ? $clog2(MUL_LAT) : 6;

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_MUL_WAIT = 2'd1;
    localparam logic [1:0] S_DIV_RUN  = 2'd2;

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   hi_q, hi_d, lo_q, lo_d;
    logic [31:0]   mul_a_q, mul_a_d, mul_b_q, mul_b_d;
    logic          busy_q, busy_d;
    logic          neg_q, neg_d, qneg_q, qneg_d, rneg_q, rneg_d;
    logic [32:0]   rem_q, rem_d;
    logic [31:0]   quo_q, quo_d;
    logic [31:0]   dvs_q, dvs_d;

    logic [32:0]   shifted;
    logic          ge;
    logic [32:0]   rem_step;
    logic [31:0]   quo_step;
    logic [63:0]   prod;
    logic          is_signed;

    function automatic logic [31:0] neg32(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

    // Magnitude of 0x80000000 wraps back to 0x80000000, which is the correct unsigned value.
    function automatic logic [31:0] mag32(input logic [31:0] v);
        return v[31] ? neg32(v) : v;
    endfunction

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        mul_a_d   = mul_a_q;
        mul_b_d   = mul_b_q;
        neg_d     = neg_q;
        qneg_d    = qneg_q;
        rneg_d    = rneg_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        is_signed = 1'b0;

        // A set top bit of R means the shifted value exceeds any 32-bit divisor.
        shifted  = {rem_q[31:0], quo_q[31]};
        ge       = rem_q[32] | (shifted >= {1'b0, dvs_q});
        rem_step = ge ? (shifted - {1'b0, dvs_q}) : shifted;
        quo_step = {quo_q[30:0], ge};
        prod     = neg_q ? (~mul_z + 64'd1) : mul_z;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            is_signed = (op == OP_MULT);
                            mul_a_d   = is_signed ? mag32(rs_val) : rs_val;
                            mul_b_d   = is_signed ? mag32(rt_val) : rt_val;
                            neg_d     = is_signed & (rs_val[31] ^ rt_val[31]);
                            cnt_d     = CW'(MUL_LAT - 1);
                            state_d   = S_MUL_WAIT;
                        end
                        OP_DIV, OP_DIVU: begin
                            if (rt_val == 32'd0) begin
                                hi_d = rs_val;
                                lo_d = 32'hFFFF_FFFF;
                            end else begin
                                is_signed = (op == OP_DIV);
                                dvs_d     = is_signed ? mag32(rt_val) : rt_val;
                                quo_d     = is_signed ? mag32(rs_val) : rs_val;
                                qneg_d    = is_signed & (rs_val[31] ^ rt_val[31]);
                                rneg_d    = is_signed & rs_val[31];
                                rem_d     = 33'd0;
                                cnt_d     = CW'(31);
                                state_d   = S_DIV_RUN;
                            end
                        end
                        OP_MTHI: hi_d = rs_val;
                        OP_MTLO: lo_d = rs_val;
                        default: ;
                    endcase
                end
            end
            S_MUL_WAIT: begin
                if (cnt_q == '0) begin
                    {hi_d, lo_d} = prod;
                    state_d      = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_DIV_RUN: begin
                rem_d = rem_step;
                quo_d = quo_step;
                // Sign fix-up is folded into the last iteration edge.
                if (cnt_q == '0) begin
                    lo_d    = qneg_q ? neg32(quo_step) : quo_step;
                    hi_d    = rneg_q ? neg32(rem_step[31:0]) : rem_step[31:0];
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            mul_a_q <= '0;
            mul_b_q <= '0;
            busy_q  <= 1'b0;
            neg_q   <= 1'b0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            mul_a_q <= mul_a_d;
            mul_b_q <= mul_b_d;
            busy_q  <= busy_d;
            neg_q   <= neg_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
        end
    end

    assign mul_a = mul_a_q;
    assign mul_b = mul_b_q;
    assign busy  = busy_q;
    assign hi    = hi_q;
    assign lo    = lo_q;

endmodule
